vga_frame_fetcher: RTL and testbench

- Single-clock AXI4 read master that fetches a framebuffer from memory in INCR bursts.
- Streams the returned words out on a valid/ready pixel-word stream.
- Sits between the VGA register file (start address, frame size, burst length, enable) and the clock-crossing pixel FIFO.
- Restarts the frame from the start address automatically while enabled.

---
 rtl/vga_fetch_pkg.sv | 28 ++
 rtl/vga_fetch_skid_buffer.sv | 55 +++++
 rtl/vga_frame_fetcher.sv | 188 ++++++++++++++++++
 tb/tb_vga_frame_fetcher.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and constants for the VGA framebuffer fetcher.
// The optional 4 KiB burst splitting is enabled with VGA_FETCH_4K_SPLIT_EN.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // AXI size encoding: log2 of the number of bytes in one data beat.
    function automatic logic [2:0] size_enc(input int unsigned data_width);
        int unsigned bytes;
        logic [2:0]  enc;
        bytes = data_width / 8;
        enc   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                enc = 3'(i);
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/vga_fetch_skid_buffer.sv
// Two-entry valid/ready register slice between the AXI R channel and the
// pixel stream. Output valid and data come straight from registers.
module vga_fetch_skid_buffer
    import vga_fetch_pkg::*;
#(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data
);

    logic [DataWidth-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 push;
    logic                 pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Store accepted words in arrival order and track occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_fetcher.sv
// AXI4 read master that fetches a framebuffer in INCR bursts, one burst in
// flight at a time, and forwards the words through a two-entry skid buffer.
// Define VGA_FETCH_4K_SPLIT_EN to keep bursts inside 4 KiB pages.
module vga_frame_fetcher
    import vga_fetch_pkg::*;
#(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned FrameWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [AddrWidth-1:0]  start_addr_i,
    input  logic [FrameWidth-1:0] frame_size_i,
    input  logic [7:0]            burst_len_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [AddrWidth-1:0]  ar_addr_o,
    output logic [7:0]            ar_len_o,
    output logic [2:0]            ar_size_o,
    output logic [1:0]            ar_burst_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [DataWidth-1:0]  r_data_i,
    input  logic                  r_last_i,
    input  logic [1:0]            r_resp_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DataWidth-1:0]  m_data_o,
    output logic                  frame_done_o,
    output logic                  err_o
);

    localparam int unsigned    BeatBytes = DataWidth / 8;
    localparam logic [2:0]     BeatSize  = size_enc(DataWidth);
    localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(BeatBytes);

    fetch_state_t          state;
    logic [AddrWidth-1:0]  cur_addr;
    logic [FrameWidth-1:0] remaining;
    logic [7:0]            burst_cfg;
    logic [8:0]            beats_left;

    logic [AddrWidth-1:0]  next_addr;
    logic [FrameWidth-1:0] next_rem;
    logic [12:0]           start_room;
    logic [12:0]           next_room;
    logic [8:0]            start_beats;
    logic [8:0]            next_beats;
    logic [8:0]            start_len;
    logic [8:0]            next_len;
    logic                  skid_ready;
    logic                  r_fire;
    logic                  unused_last;

    // Beats in the next burst: configured length, clipped to what is left of
    // the frame and to the room left in the current page.
    function automatic logic [8:0] calc_beats(input logic [FrameWidth-1:0] rem,
                                              input logic [7:0]            blen,
                                              input logic [12:0]           room);
        logic [8:0] beats;
        beats = {1'b0, blen} + 9'd1;
        if (rem < FrameWidth'(beats)) begin
            beats = rem[8:0];
        end
        if (room < {4'b0000, beats}) begin
            beats = room[8:0];
        end
        return beats;
    endfunction

`ifdef VGA_FETCH_4K_SPLIT_EN
    // Beats that fit between an aligned address and the next 4 KiB boundary.
    function automatic logic [12:0] page_room(input logic [AddrWidth-1:0] addr);
        return (13'd4096 - {1'b0, addr[11:0]}) >> BeatSize;
    endfunction

    assign start_room = page_room(start_addr_i);
    assign next_room  = page_room(next_addr);
`else
    assign start_room = 13'd4096;
    assign next_room  = 13'd4096;
`endif

    assign next_addr   = cur_addr + AddrStep;
    assign next_rem    = remaining - FrameWidth'(1);
    assign start_beats = calc_beats(frame_size_i, burst_len_i, start_room);
    assign next_beats  = calc_beats(next_rem, burst_cfg, next_room);
    assign start_len   = start_beats - 9'd1;
    assign next_len    = next_beats - 9'd1;

    assign r_fire      = r_valid_i && r_ready_o;
    assign r_ready_o   = (state == DATA) && skid_ready;
    assign ar_addr_o   = cur_addr;
    assign ar_size_o   = BeatSize;
    assign ar_burst_o  = AXI_BURST_INCR;
    assign unused_last = r_last_i;

    // Fetch sequencing: latch config at frame start, issue one burst, count
    // its beats back, then either issue the next burst, restart or stop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cur_addr     <= '0;
            remaining    <= '0;
            burst_cfg    <= '0;
            beats_left   <= '0;
            ar_valid_o   <= 1'b0;
            ar_len_o     <= '0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;

            if (r_fire && (r_resp_i != RESP_OKAY)) begin
                err_o <= 1'b1;
            end else if ((state == IDLE) && !enable_i) begin
                err_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable_i && (frame_size_i != '0)) begin
                        cur_addr   <= start_addr_i;
                        remaining  <= frame_size_i;
                        burst_cfg  <= burst_len_i;
                        ar_len_o   <= start_len[7:0];
                        ar_valid_o <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_ready_i) begin
                        ar_valid_o <= 1'b0;
                        beats_left <= {1'b0, ar_len_o} + 9'd1;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (r_fire) begin
                        cur_addr   <= next_addr;
                        remaining  <= next_rem;
                        beats_left <= beats_left - 9'd1;
                        if (beats_left == 9'd1) begin
                            if (next_rem == '0) begin
                                frame_done_o <= 1'b1;
                                if (enable_i && (frame_size_i != '0)) begin
                                    cur_addr   <= start_addr_i;
                                    remaining  <= frame_size_i;
                                    burst_cfg  <= burst_len_i;
                                    ar_len_o   <= start_len[7:0];
                                    ar_valid_o <= 1'b1;
                                    state      <= ADDR;
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (enable_i) begin
                                ar_len_o   <= next_len[7:0];
                                ar_valid_o <= 1'b1;
                                state      <= ADDR;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    vga_fetch_skid_buffer #(
        .DataWidth(DataWidth)
    ) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_valid (r_valid_i && (state == DATA)),
        .in_ready (skid_ready),
        .in_data  (r_data_i),
        .out_valid(m_valid_o),
        .out_ready(m_ready_i),
        .out_data (m_data_o)
    );

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// Self-checking bench for vga_frame_fetcher: a behavioural AXI read slave,
// a stream scoreboard, a table of frame scenarios and hand-written corner
// sequences. Honours VGA_FETCH_4K_SPLIT_EN for the page-boundary vector.
module tb_vga_frame_fetcher;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [63:0] start_addr_i;
    logic [31:0] frame_size_i;
    logic [7:0]  burst_len_i;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        r_valid_i;
    logic        r_ready_o;
    logic [63:0] r_data_i;
    logic        r_last_i;
    logic [1:0]  r_resp_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [63:0] m_data_o;
    logic        frame_done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    vga_frame_fetcher #(
        .AddrWidth (64),
        .DataWidth (64),
        .FrameWidth(32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .start_addr_i(start_addr_i),
        .frame_size_i(frame_size_i),
        .burst_len_i (burst_len_i),
        .ar_valid_o  (ar_valid_o),
        .ar_ready_i  (ar_ready_i),
        .ar_addr_o   (ar_addr_o),
        .ar_len_o    (ar_len_o),
        .ar_size_o   (ar_size_o),
        .ar_burst_o  (ar_burst_o),
        .r_valid_i   (r_valid_i),
        .r_ready_o   (r_ready_o),
        .r_data_i    (r_data_i),
        .r_last_i    (r_last_i),
        .r_resp_i    (r_resp_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .frame_done_o(frame_done_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic [63:0]        addr;
        logic [7:0]         len;
    } ar_rec_t;

    typedef struct {
        logic [63:0]        start;
        logic [31:0]        frame;
        logic [7:0]         blen;
        int                 ar_delay;
        int                 n_ar;
        logic [3:0][63:0]   addr;
        logic [3:0][7:0]    len;
    } vec_t;

    int          compared = 0;
    int          mismatched = 0;
    ar_rec_t     ar_log[$];
    ar_rec_t     burst_q[$];
    int          beat_idx;
    int          ar_delay = 0;
    int          ar_wait;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = '0;
    logic [63:0] slave_addr;
    int          r_cnt = 0;
    int          fd_cnt = 0;
    int          word_k = 0;
    logic [63:0] exp_start = '0;
    int          exp_frame = 1;
    int          hold_err = 0;
    int          ar_hold_err = 0;
    logic        m_hold_prev = 1'b0;
    logic [63:0] m_hold_data = '0;
    logic        ar_hold_prev = 1'b0;
    ar_rec_t     ar_hold_rec;
    vec_t        vecs[6];
    int          n_vecs;

    // Memory contents seen by the slave: a pattern unique to each address.
    function automatic logic [63:0] data_of(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_F00D, ~a[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [63:0] start,
                                 input logic [31:0] frame, input logic [7:0] blen);
        @(posedge clk_i);
        #1;
        enable_i     = en;
        start_addr_i = start;
        frame_size_i = frame;
        burst_len_i  = blen;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic waitFrameDone(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            if (frame_done_o) seen = 1'b1;
        end
        if (!seen) checkOutput({name, "_frame_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic waitWords(input string name, input int target, input int budget);
        for (int i = 0; i < budget && word_k < target; i++) @(negedge clk_i);
        if (word_k < target) checkOutput({name, "_words_timeout"}, 64'(word_k), 64'(target));
    endtask

    task automatic initScoreboard(input logic [63:0] start, input int frame);
        ar_log.delete();
        fd_cnt      = 0;
        word_k      = 0;
        r_cnt       = 0;
        hold_err    = 0;
        ar_hold_err = 0;
        exp_start   = start;
        exp_frame   = frame;
    endtask

    function automatic logic [63:0] logAddr(input int i);
        return (i < ar_log.size()) ? ar_log[i].addr : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [7:0] logLen(input int i);
        return (i < ar_log.size()) ? ar_log[i].len : 8'hEE;
    endfunction

    task automatic setVec(input int idx, input logic [63:0] start, input logic [31:0] frame,
                          input logic [7:0] blen, input int dly, input int n,
                          input logic [63:0] a0, input logic [7:0] l0,
                          input logic [63:0] a1, input logic [7:0] l1,
                          input logic [63:0] a2, input logic [7:0] l2,
                          input logic [63:0] a3, input logic [7:0] l3);
        vecs[idx].start    = start;
        vecs[idx].frame    = frame;
        vecs[idx].blen     = blen;
        vecs[idx].ar_delay = dly;
        vecs[idx].n_ar     = n;
        vecs[idx].addr[0]  = a0; vecs[idx].len[0] = l0;
        vecs[idx].addr[1]  = a1; vecs[idx].len[1] = l1;
        vecs[idx].addr[2]  = a2; vecs[idx].len[2] = l2;
        vecs[idx].addr[3]  = a3; vecs[idx].len[3] = l3;
    endtask

    // AXI read slave: accepts one AR at a time after ar_delay stall cycles and
    // returns its beats back to back from the address-derived pattern.
    initial begin
        r_valid_i  = 1'b0;
        r_data_i   = '0;
        r_last_i   = 1'b0;
        r_resp_i   = 2'b00;
        ar_ready_i = 1'b0;
        beat_idx   = 0;
        ar_wait    = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                burst_q.delete();
                beat_idx = 0;
                ar_wait  = 0;
            end else begin
                if (r_valid_i && r_ready_o) begin
                    r_cnt++;
                    if (beat_idx == int'(burst_q[0].len)) begin
                        void'(burst_q.pop_front());
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                if (ar_valid_o && ar_ready_i) begin
                    burst_q.push_back('{ar_addr_o, ar_len_o});
                    ar_log.push_back('{ar_addr_o, ar_len_o});
                    ar_wait = 0;
                end else if (ar_valid_o) begin
                    ar_wait++;
                end
            end
            @(posedge clk_i);
            #1;
            ar_ready_i = (ar_wait >= ar_delay);
            if (burst_q.size() != 0) begin
                slave_addr = burst_q[0].addr + 64'(beat_idx * 8);
                r_valid_i  = 1'b1;
                r_data_i   = data_of(slave_addr);
                r_last_i   = (beat_idx == int'(burst_q[0].len));
                r_resp_i   = (err_en && slave_addr == err_addr) ? 2'b10 : 2'b00;
            end else begin
                r_valid_i = 1'b0;
                r_data_i  = '0;
                r_last_i  = 1'b0;
                r_resp_i  = 2'b00;
            end
        end
    end

    // Stream scoreboard and handshake-stability watchers.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (frame_done_o) fd_cnt++;
                if (m_hold_prev && !(m_valid_o && m_data_o == m_hold_data)) hold_err++;
                m_hold_prev = m_valid_o && !m_ready_i;
                m_hold_data = m_data_o;
                if (ar_hold_prev && !(ar_valid_o && ar_addr_o == ar_hold_rec.addr &&
                                      ar_len_o == ar_hold_rec.len)) ar_hold_err++;
                ar_hold_prev = ar_valid_o && !ar_ready_i;
                ar_hold_rec  = '{ar_addr_o, ar_len_o};
                if (m_valid_o && m_ready_i) begin
                    checkOutput($sformatf("stream_word%0d", word_k), m_data_o,
                                data_of(exp_start + 64'(8 * (word_k % exp_frame))));
                    word_k++;
                end
            end
        end
    end

    initial begin
        int exp_words;
        int r_mid;
        rst_i        = 1'b1;
        enable_i     = 1'b0;
        start_addr_i = '0;
        frame_size_i = '0;
        burst_len_i  = '0;
        m_ready_i    = 1'b1;

        // Scenario table: restart AR always returns to start with len[0].
        setVec(0, 64'h1000, 16, 3, 0, 4, 64'h1000, 3, 64'h1020, 3, 64'h1040, 3, 64'h1060, 3);
        setVec(1, 64'h2000, 10, 3, 2, 3, 64'h2000, 3, 64'h2020, 3, 64'h2040, 1, 64'h0, 0);
        setVec(2, 64'h3008, 5, 7, 0, 1, 64'h3008, 4, 64'h0, 0, 64'h0, 0, 64'h0, 0);
        setVec(3, 64'hFFFF_FFFF_FFFF_FFF0, 4, 1, 1, 2, 64'hFFFF_FFFF_FFFF_FFF0, 1,
               64'h0, 1, 64'h0, 0, 64'h0, 0);
        setVec(4, 64'h4000, 3, 0, 0, 3, 64'h4000, 0, 64'h4008, 0, 64'h4010, 0, 64'h0, 0);
`ifdef VGA_FETCH_4K_SPLIT_EN
        setVec(5, 64'h0FE0, 16, 15, 0, 2, 64'h0FE0, 3, 64'h1000, 11, 64'h0, 0, 64'h0, 0);
`else
        setVec(5, 64'h0FE0, 16, 15, 0, 1, 64'h0FE0, 15, 64'h0, 0, 64'h0, 0, 64'h0, 0);
`endif
        n_vecs = 6;

        waitCycles(3);
        checkOutput("rst_ar_valid", 64'(ar_valid_o), 64'd0);
        checkOutput("rst_ar_addr", ar_addr_o, 64'd0);
        checkOutput("rst_ar_len", 64'(ar_len_o), 64'd0);
        checkOutput("rst_r_ready", 64'(r_ready_o), 64'd0);
        checkOutput("rst_m_valid", 64'(m_valid_o), 64'd0);
        checkOutput("rst_m_data", m_data_o, 64'd0);
        checkOutput("rst_frame_done", 64'(frame_done_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        waitCycles(2);
        checkOutput("ar_size", 64'(ar_size_o), 64'd3);
        checkOutput("ar_burst", 64'(ar_burst_o), 64'd1);

        // Zero-length frame must never leave IDLE.
        initScoreboard(64'h8000, 1);
        applyStimulus(1'b1, 64'h8000, 32'd0, 8'd3);
        waitCycles(10);
        checkOutput("zero_frame_ar_count", 64'(ar_log.size()), 64'd0);
        checkOutput("zero_frame_ar_valid", 64'(ar_valid_o), 64'd0);
        applyStimulus(1'b0, 64'h8000, 32'd0, 8'd3);
        waitCycles(2);

        for (int v = 0; v < n_vecs; v++) begin
            initScoreboard(vecs[v].start, int'(vecs[v].frame));
            ar_delay = vecs[v].ar_delay;
            applyStimulus(1'b1, vecs[v].start, vecs[v].frame, vecs[v].blen);
            waitFrameDone($sformatf("v%0d", v), 3000);
            applyStimulus(1'b0, 64'hDEAD_0000, 32'd7, 8'd0);
            exp_words = int'(vecs[v].frame) + int'(vecs[v].len[0]) + 1;
            waitWords($sformatf("v%0d", v), exp_words, 3000);
            waitCycles(20);
            checkOutput($sformatf("v%0d_ar_count", v), 64'(ar_log.size()), 64'(vecs[v].n_ar + 1));
            for (int i = 0; i < vecs[v].n_ar; i++) begin
                checkOutput($sformatf("v%0d_ar%0d_addr", v, i), logAddr(i), vecs[v].addr[i]);
                checkOutput($sformatf("v%0d_ar%0d_len", v, i), 64'(logLen(i)), 64'(vecs[v].len[i]));
            end
            checkOutput($sformatf("v%0d_restart_addr", v), logAddr(vecs[v].n_ar), vecs[v].start);
            checkOutput($sformatf("v%0d_restart_len", v), 64'(logLen(vecs[v].n_ar)),
                        64'(vecs[v].len[0]));
            checkOutput($sformatf("v%0d_frame_done_count", v), 64'(fd_cnt),
                        (vecs[v].n_ar == 1) ? 64'd2 : 64'd1);
            checkOutput($sformatf("v%0d_word_count", v), 64'(word_k), 64'(exp_words));
            checkOutput($sformatf("v%0d_ar_hold", v), 64'(ar_hold_err), 64'd0);
            checkOutput($sformatf("v%0d_idle_ar_valid", v), 64'(ar_valid_o), 64'd0);
        end
        ar_delay = 0;

        // Downstream stall for 20 cycles in the middle of an 8-beat burst.
        initScoreboard(64'h5000, 8);
        applyStimulus(1'b1, 64'h5000, 32'd8, 8'd7);
        for (int i = 0; i < 100 && ar_log.size() == 0; i++) @(negedge clk_i);
        applyStimulus(1'b0, 64'h5000, 32'd8, 8'd7);
        waitWords("stall", 3, 200);
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b0;
        waitCycles(10);
        checkOutput("stall_r_ready", 64'(r_ready_o), 64'd0);
        checkOutput("stall_m_valid", 64'(m_valid_o), 64'd1);
        r_mid = r_cnt;
        waitCycles(10);
        checkOutput("stall_no_r_beats", 64'(r_cnt), 64'(r_mid));
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        waitWords("stall", 8, 200);
        waitCycles(20);
        checkOutput("stall_word_count", 64'(word_k), 64'd8);
        checkOutput("stall_frame_done", 64'(fd_cnt), 64'd1);
        checkOutput("stall_ar_count", 64'(ar_log.size()), 64'd1);
        checkOutput("stall_hold", 64'(hold_err), 64'd0);

        // Enable drops during the second beat of a 4-beat burst.
        initScoreboard(64'h6000, 16);
        applyStimulus(1'b1, 64'h6000, 32'd16, 8'd3);
        for (int i = 0; i < 100 && r_cnt < 1; i++) @(negedge clk_i);
        applyStimulus(1'b0, 64'h6000, 32'd16, 8'd3);
        waitWords("drop", 4, 200);
        waitCycles(30);
        checkOutput("drop_word_count", 64'(word_k), 64'd4);
        checkOutput("drop_r_beats", 64'(r_cnt), 64'd4);
        checkOutput("drop_ar_count", 64'(ar_log.size()), 64'd1);
        checkOutput("drop_frame_done", 64'(fd_cnt), 64'd0);
        checkOutput("drop_idle_ar_valid", 64'(ar_valid_o), 64'd0);
        checkOutput("drop_idle_r_ready", 64'(r_ready_o), 64'd0);

        // Error response on one beat: sticky until IDLE with enable low.
        initScoreboard(64'h7000, 4);
        err_en   = 1'b1;
        err_addr = 64'h7010;
        checkOutput("err_before", 64'(err_o), 64'd0);
        applyStimulus(1'b1, 64'h7000, 32'd4, 8'd3);
        waitFrameDone("err", 500);
        checkOutput("err_set", 64'(err_o), 64'd1);
        applyStimulus(1'b0, 64'h7000, 32'd4, 8'd3);
        waitCycles(1);
        checkOutput("err_held_busy", 64'(err_o), 64'd1);
        waitWords("err", 8, 200);
        waitCycles(5);
        checkOutput("err_cleared", 64'(err_o), 64'd0);
        checkOutput("err_word_count", 64'(word_k), 64'd8);
        err_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
